// File: rtl/sixteen_bit_counter_pkg.sv
// Shared definitions for the sixteen_bit_counter block.
// Contents:
//   DEFAULT_WIDTH        default counter width in bits
//   DEFAULT_RESET_VALUE  default value loaded into count on reset
//   dir_e                count direction encoding of the up_down input
package sixteen_bit_counter_pkg;

    localparam int unsigned DEFAULT_WIDTH       = 16;
    localparam int unsigned DEFAULT_RESET_VALUE = 0;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

endpackage

// File: rtl/sixteen_bit_counter_if.sv
// Bus bundle between the counter and the logic that controls it.
// Signals:
//   en, up_down, clear, load   control inputs to the counter
//   load_value                 parallel load data
//   cmp_value                  compare threshold for match
//   count                      registered counter value
//   tc                         combinational terminal count
//   wrap                       registered one-cycle wrap pulse
//   match                      registered count==cmp_value flag
// Modports: master drives controls and observes status; slave is the counter.
interface sixteen_bit_counter_if
    import sixteen_bit_counter_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
);

    logic             en;
    logic             up_down;
    logic             clear;
    logic             load;
    logic [WIDTH-1:0] load_value;
    logic [WIDTH-1:0] cmp_value;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             wrap;
    logic             match;

    modport master (
        output en, up_down, clear, load, load_value, cmp_value,
        input  count, tc, wrap, match
    );

    modport slave (
        input  en, up_down, clear, load, load_value, cmp_value,
        output count, tc, wrap, match
    );

endinterface

// File: rtl/sixteen_bit_counter_next.sv
// Combinational next-state logic for the counter.
// Ports:
//   count_i       current count
//   en_i          count enable
//   up_down_i     direction (DIR_UP / DIR_DOWN)
//   clear_i       clear to zero, highest priority
//   load_i        parallel load, below clear
//   load_value_i  load data
//   next_count_o  count value for the next clock edge
//   wrap_next_o   set when this step crosses the all-ones/zero boundary
module sixteen_bit_counter_next
    import sixteen_bit_counter_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] count_i,
    input  logic             en_i,
    input  logic             up_down_i,
    input  logic             clear_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_value_i,
    output logic [WIDTH-1:0] next_count_o,
    output logic             wrap_next_o
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    dir_e dir;
    assign dir = dir_e'(up_down_i);

    always_comb begin
        next_count_o = count_i;
        wrap_next_o  = 1'b0;
        if (clear_i) begin
            next_count_o = '0;
        end else if (load_i) begin
            next_count_o = load_value_i;
        end else if (en_i) begin
            if (dir == DIR_UP) begin
                next_count_o = count_i + ONE;
                wrap_next_o  = (count_i == '1);
            end else begin
                next_count_o = count_i - ONE;
                wrap_next_o  = (count_i == '0);
            end
        end
    end

endmodule

// File: rtl/sixteen_bit_counter.sv
// 16-bit synchronous up/down counter with enable, clear, load, terminal
// count, wrap pulse and compare match.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-low reset
//   bus    slave side of sixteen_bit_counter_if (controls in, status out)
module sixteen_bit_counter
    import sixteen_bit_counter_pkg::*;
#(
    parameter int unsigned      WIDTH       = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(DEFAULT_RESET_VALUE)
) (
    input logic                 clk,
    input logic                 reset,
    sixteen_bit_counter_if.slave bus
);

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;
    logic             match_q, match_d;

    sixteen_bit_counter_next #(
        .WIDTH (WIDTH)
    ) u_next (
        .count_i      (count_q),
        .en_i         (bus.en),
        .up_down_i    (bus.up_down),
        .clear_i      (bus.clear),
        .load_i       (bus.load),
        .load_value_i (bus.load_value),
        .next_count_o (count_d),
        .wrap_next_o  (wrap_d)
    );

    // Compare against the upcoming value so match lines up with the
    // count it describes rather than lagging it by a cycle.
    assign match_d = (count_d == bus.cmp_value);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= RESET_VALUE;
            wrap_q  <= 1'b0;
            match_q <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
            match_q <= match_d;
        end
    end

    always_comb begin
        bus.tc = 1'b0;
        if (dir_e'(bus.up_down) == DIR_UP) begin
            bus.tc = (count_q == '1);
        end else begin
            bus.tc = (count_q == '0);
        end
    end

    assign bus.count = count_q;
    assign bus.wrap  = wrap_q;
    assign bus.match = match_q;

endmodule

// File: tb/tb_sixteen_bit_counter.sv
// Self-checking bench for sixteen_bit_counter: directed scenarios plus
// randomized traffic, compared against an arithmetic reference model.
module tb_sixteen_bit_counter;

    localparam int unsigned MODULUS = 65536;

    logic clk;
    logic reset;

    sixteen_bit_counter_if #(.WIDTH(16)) bus ();

    sixteen_bit_counter #(
        .WIDTH       (16),
        .RESET_VALUE (16'h0000)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    // Reference model state: what the counter should show after the last edge.
    int unsigned m_count = 0;
    bit          m_wrap  = 1'b0;
    bit          m_match = 1'b0;
    int unsigned wraps_seen = 0;

    task automatic check_eq(input string tag, input logic [31:0] act,
                            input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // One clock: advance the model from the currently driven inputs, then
    // compare outputs on the falling edge.
    task automatic tick(input bit do_check);
        int unsigned c;
        int unsigned n;
        bit          w;
        @(posedge clk);
        c = m_count;
        w = 1'b0;
        if (bus.clear) begin
            n = 0;
        end else if (bus.load) begin
            n = int'(bus.load_value);
        end else if (bus.en && bus.up_down) begin
            n = (c + 1) % MODULUS;
            w = (c == MODULUS - 1);
        end else if (bus.en) begin
            n = (c + MODULUS - 1) % MODULUS;
            w = (c == 0);
        end else begin
            n = c;
        end
        m_count = n;
        m_wrap  = w;
        m_match = (n == int'(bus.cmp_value));
        @(negedge clk);
        if (bus.wrap === 1'b1) wraps_seen++;
        if (do_check) begin
            check_eq("count", 32'(bus.count), 32'(m_count));
            check_eq("wrap", 32'(bus.wrap), 32'(m_wrap));
            check_eq("match", 32'(bus.match), 32'(m_match));
            check_eq("tc", 32'(bus.tc),
                     32'(bus.up_down ? (m_count == MODULUS - 1) : (m_count == 0)));
        end
    endtask

    task automatic set_ctrl(input bit en, input bit up, input bit clr, input bit ld,
                            input logic [15:0] lv);
        bus.en         = en;
        bus.up_down    = up;
        bus.clear      = clr;
        bus.load       = ld;
        bus.load_value = lv;
    endtask

    initial begin
        reset         = 1'b0;
        bus.cmp_value = 16'h8000;
        set_ctrl(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);

        // Reset held across a rising edge: nothing may move.
        #12;
        check_eq("rst_count", 32'(bus.count), 32'h0);
        check_eq("rst_wrap", 32'(bus.wrap), 32'h0);
        check_eq("rst_match", 32'(bus.match), 32'h0);
        #5;
        check_eq("rst_hold", 32'(bus.count), 32'h0);
        #3;
        reset = 1'b1;

        for (int i = 0; i < 100; i++) tick(1'b1);
        check_eq("cnt100", 32'(bus.count), 32'd100);

        // Up-count wrap from a loaded 0xFFFE.
        set_ctrl(1'b1, 1'b1, 1'b0, 1'b1, 16'hFFFE);
        tick(1'b1);
        check_eq("ld_fffe", 32'(bus.count), 32'hFFFE);
        set_ctrl(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
        tick(1'b1);
        check_eq("tc_up", 32'(bus.tc), 32'h1);
        tick(1'b1);
        check_eq("wrap_up", 32'(bus.wrap), 32'h1);
        check_eq("wrap_up_cnt", 32'(bus.count), 32'h0);
        tick(1'b1);
        check_eq("wrap_up_end", 32'(bus.wrap), 32'h0);

        // Down-count wrap from a loaded 0x0002.
        set_ctrl(1'b1, 1'b0, 1'b0, 1'b1, 16'h0002);
        tick(1'b1);
        set_ctrl(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        tick(1'b1);
        tick(1'b1);
        check_eq("tc_down", 32'(bus.tc), 32'h1);
        tick(1'b1);
        check_eq("wrap_dn", 32'(bus.wrap), 32'h1);
        check_eq("wrap_dn_cnt", 32'(bus.count), 32'hFFFF);
        tick(1'b1);

        // Hold with en low, then clear beats load.
        set_ctrl(1'b1, 1'b1, 1'b0, 1'b1, 16'h0010);
        tick(1'b1);
        set_ctrl(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
        for (int i = 0; i < 5; i++) tick(1'b1);
        check_eq("hold", 32'(bus.count), 32'h10);
        set_ctrl(1'b1, 1'b1, 1'b1, 1'b1, 16'h1234);
        tick(1'b1);
        check_eq("clr_wins", 32'(bus.count), 32'h0);

        // Load with en high: no extra increment.
        set_ctrl(1'b1, 1'b1, 1'b0, 1'b1, 16'h0777);
        tick(1'b1);
        check_eq("ld_no_inc", 32'(bus.count), 32'h777);

        // Compare match while counting up from 0.
        bus.cmp_value = 16'h0005;
        set_ctrl(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000);
        tick(1'b1);
        set_ctrl(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
        for (int i = 1; i <= 8; i++) begin
            tick(1'b1);
            check_eq("match_cmp5", 32'(bus.match), 32'(i == 5));
        end

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            set_ctrl(($urandom_range(0, 9) != 0), 1'($urandom),
                     ($urandom_range(0, 24) == 0), ($urandom_range(0, 14) == 0),
                     16'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                bus.load_value = ($urandom_range(0, 1) != 0) ? 16'hFFFF : 16'h0000;
            end
            if ($urandom_range(0, 7) == 0) begin
                bus.cmp_value = 16'((m_count + $urandom_range(0, 4)) % MODULUS);
            end
            tick(1'b1);
        end

        // Full free-run lap from zero: one wrap, back at the start.
        bus.cmp_value = 16'h8000;
        set_ctrl(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000);
        tick(1'b1);
        set_ctrl(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
        wraps_seen = 0;
        for (int i = 0; i < MODULUS; i++) tick(1'b0);
        check_eq("lap_count", 32'(bus.count), 32'h0);
        check_eq("lap_wraps", 32'(wraps_seen), 32'd1);
        check_eq("lap_model", 32'(bus.count), 32'(m_count));

        // Asynchronous reset mid-cycle.
        for (int i = 0; i < 7; i++) tick(1'b1);
        #2;
        reset = 1'b0;
        #1;
        check_eq("async_cnt", 32'(bus.count), 32'h0);
        check_eq("async_match", 32'(bus.match), 32'h0);
        check_eq("async_wrap", 32'(bus.wrap), 32'h0);
        @(posedge clk);
        #1;
        check_eq("async_hold", 32'(bus.count), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sixteen_bit_counter.md
Name: sixteen_bit_counter

Overview:
16-bit synchronous up/down counter with enable, synchronous clear, parallel load, terminal-count and wrap flags, and a compare-match output. It is a general-purpose timebase/event counter used by surrounding control logic. After reset, with enable held high and direction "up", it free-runs 0, 1, 2, … and wraps modulo 2^16.

Parameters:
WIDTH, 16, counter width in bits; all count-related ports scale with it.
RESET_VALUE, 0, value loaded into count on asynchronous reset.

Ports:
clk  input  1  rising-edge clock; sole clock domain.
reset  input  1  asynchronous, active-low reset; clears all state while low.
en  input  1  count enable; the counter advances only when high.
up_down  input  1  1 = count up, 0 = count down.
clear  input  1  synchronous clear to 0; highest synchronous priority.
load  input  1  synchronous parallel load of load_value.
load_value  input  WIDTH  value taken when load is high.
cmp_value  input  WIDTH  compare threshold.
count  output  WIDTH  current counter value, registered.
tc  output  1  combinational terminal count: high when count==2^WIDTH-1 while up_down=1, or count==0 while up_down=0.
wrap  output  1  registered one-cycle pulse, high in the cycle after count wrapped (0xFFFF→0x0000 up, or 0x0000→0xFFFF down).
match  output  1  registered; high while count==cmp_value.

Behaviour:
- Reset low (asynchronous, immediate): count=RESET_VALUE (0), wrap=0, match=(RESET_VALUE==cmp_value) from the first clock after release. While reset is low, match is forced to 0.
- On release, the counter holds its value until the first rising edge with reset high. Release is synchronous-safe: state changes only on clk edges.
- Per rising edge, priority order:
  1. clear: count←0, wrap←0.
  2. load: count←load_value, wrap←0.
  3. en and up_down: count←count+1 mod 2^WIDTH; wrap←(count was all-ones).
  4. en and not up_down: count←count−1 mod 2^WIDTH; wrap←(count was 0).
  5. Otherwise hold count; wrap←0.
- Latency: one cycle from a control input to the new count value. wrap asserts in the same cycle the wrapped value appears on count and lasts exactly one cycle.
- match is registered from the next count value, so match==1 exactly when the currently displayed count equals cmp_value.
- Arithmetic is unsigned modulo 2^WIDTH; no saturation.
- Free-running up: 65536 enabled cycles return count to its starting value, with exactly one wrap pulse.
- clear and load asserted together: clear wins. load with en: load wins, with no increment that cycle.
- Reset mid-count: count goes to 0 immediately, without waiting for a clock edge.
- Inputs are synchronous to clk. Outputs have no X after reset when the inputs are driven.

Decomposition:
- Shared package: WIDTH default constant (16), RESET_VALUE, and an enum for direction (DIR_DOWN=0, DIR_UP=1).
- One natural sub-module: counter_next, a purely combinational block that takes count, en, up_down, clear, load and load_value, and returns next_count plus a wrap_next flag.
- The top level holds the registers, tc and match.

Test Plan:
- Hold reset low for 20 ns, then release with en=1 and up_down=1 (10 ns clock) → count=0 during reset; count=100 after 100 rising edges.
- Load 0xFFFE with en=1 and up_down=1 → count goes 0xFFFE, 0xFFFF (tc=1), 0x0000 with wrap=1 for one cycle, then 0x0001 with wrap=0.
- Down-count from load 0x0002 → 0x0001, 0x0000 (tc=1), 0xFFFF with wrap=1.
- Set en=0 for 5 cycles at count=0x0010 → count stays 0x0010; then clear=1 together with load=1 (load_value 0x1234) → count=0x0000.
- Set cmp_value=0x0005 and count up from 0 → match=1 only in the cycle count=0x0005.
- Free-run for 65536 cycles from 0 → count=0 again, exactly one wrap pulse. Then drive reset low mid-cycle → count=0 immediately, before the next edge.
